shift_rx: RTL and testbench



---
 rtl/shift_rx_pkg.sv | 39 +++
 rtl/shift_rx_bit_sync.sv | 34 +++
 rtl/shift_rx.sv | 201 ++++++++++++++++++++
 tb/tb_shift_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_rx_pkg.sv
// -----------------------------------------------------------------------------
// shift_rx_pkg
// Shared types and helpers for the shift_rx serial receiver.
//   state_t        : receiver FSM states (BREAK only exists when
//                    SHIFT_RX_FRAME_CHECK_EN is defined)
//   cnt_width()    : width helper for the prescaler and bit counter
//   half_reload()  : prescaler reload value that lands on the middle of the
//                    start bit
// -----------------------------------------------------------------------------
package shift_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef SHIFT_RX_FRAME_CHECK_EN
    ,
    BREAK = 3'd4
`endif
  } state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // The prescaler counts down to zero and the sample happens on the edge that
  // sees zero, so a reload of L places the sample L+1 edges after the load.
  // Landing CLOCKS_PER_BIT/2 edges after T0 therefore needs L = cpb/2 - 1.
  function automatic int half_reload(input int cpb);
    return (cpb / 2) - 1;
  endfunction

endpackage : shift_rx_pkg

// File: rtl/shift_rx_bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   i_clk   : clock, all logic on posedge
//   i_reset : synchronous, active-high reset; both flops load RESET_VAL
//   i_d     : asynchronous input
//   o_q     : synchronized output, two cycles behind i_d
// Parameter:
//   RESET_VAL : value both flops take in reset (default 1 = idle serial line)
// -----------------------------------------------------------------------------
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta <= RESET_VAL;
      o_q  <= RESET_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule : bit_sync

// File: rtl/shift_rx.sv
// -----------------------------------------------------------------------------
// shift_rx
// Serial-to-parallel receiver: idle-high line, start bit 0, DATA_WIDTH data
// bits LSB first, stop bit 1. Bit timing from an internal down-counting
// prescaler; each received word is presented on o_data with a one-cycle
// o_valid strobe.
// Parameters:
//   CLOCKS_PER_BIT : i_clk cycles per serial bit (>= 4)
//   DATA_WIDTH     : data bits per frame (>= 2)
// Ports:
//   i_clk       : system clock, all logic on posedge
//   i_reset     : synchronous, active-high reset
//   i_serial    : asynchronous serial line, idle high
//   o_data      : last received word, held until the next valid frame
//   o_valid     : one-cycle pulse, o_data updated in the same cycle
//   o_busy      : high in every state except IDLE
//   o_frame_err : (SHIFT_RX_FRAME_CHECK_EN only) one-cycle pulse when the
//                 stop bit samples 0
// Build option:
//   SHIFT_RX_FRAME_CHECK_EN : adds stop-bit checking, o_frame_err and the
//                             BREAK state that waits for the line to go high.
// -----------------------------------------------------------------------------
module shift_rx
  import shift_rx_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 16,
  parameter int DATA_WIDTH     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_serial,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_busy
`ifdef SHIFT_RX_FRAME_CHECK_EN
  ,
  output logic                  o_frame_err
`endif
);

  localparam int PW = cnt_width(CLOCKS_PER_BIT);
  localparam int BW = cnt_width(DATA_WIDTH);

  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = PW'(32'd1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(half_reload(CLOCKS_PER_BIT));
  localparam logic [PW-1:0] PRESC_FULL = PW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_ZERO   = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE    = BW'(32'd1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);

  logic                  rx_s;
  state_t                state;
  state_t                state_next;
  logic [PW-1:0]         presc;
  logic [PW-1:0]         presc_next;
  logic [BW-1:0]         bitcnt;
  logic [BW-1:0]         bitcnt_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  valid_next;
  logic                  sample;
`ifdef SHIFT_RX_FRAME_CHECK_EN
  logic                  ferr_next;
`endif

  bit_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_serial),
    .o_q     (rx_s)
  );

  // The prescaler reaching zero marks a sample edge in START/DATA/STOP.
  assign sample = (presc == PRESC_ZERO);

  // Next-state, datapath and output decode for the receiver FSM.
  always_comb begin
    state_next  = state;
    presc_next  = presc;
    bitcnt_next = bitcnt;
    shreg_next  = shreg;
    data_next   = o_data;
    valid_next  = 1'b0;
`ifdef SHIFT_RX_FRAME_CHECK_EN
    ferr_next   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          presc_next = PRESC_HALF;
        end else begin
          presc_next = presc;
        end
      end

      START: begin
        if (sample) begin
          presc_next  = PRESC_FULL;
          bitcnt_next = BIT_ZERO;
          if (!rx_s) begin
            state_next = DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_next = IDLE;
          end
        end else begin
          presc_next = presc - PRESC_ONE;
        end
      end

      DATA: begin
        if (sample) begin
          presc_next = PRESC_FULL;
          shreg_next = {rx_s, shreg[DATA_WIDTH-1:1]};
          if (bitcnt == BIT_LAST) begin
            state_next  = STOP;
            bitcnt_next = BIT_ZERO;
          end else begin
            bitcnt_next = bitcnt + BIT_ONE;
          end
        end else begin
          presc_next = presc - PRESC_ONE;
        end
      end

      STOP: begin
        if (sample) begin
          presc_next = PRESC_FULL;
`ifdef SHIFT_RX_FRAME_CHECK_EN
          if (rx_s) begin
            state_next = IDLE;
            data_next  = shreg;
            valid_next = 1'b1;
          end else begin
            state_next = BREAK;
            ferr_next  = 1'b1;
          end
`else
          state_next = IDLE;
          data_next  = shreg;
          valid_next = 1'b1;
`endif
        end else begin
          presc_next = presc - PRESC_ONE;
        end
      end

`ifdef SHIFT_RX_FRAME_CHECK_EN
      BREAK: begin
        // Hold off new frames until the line has recovered to idle.
        if (rx_s) begin
          state_next = IDLE;
          presc_next = PRESC_FULL;
        end else begin
          presc_next = presc;
        end
      end
`endif

      default: begin
        state_next  = IDLE;
        presc_next  = PRESC_ZERO;
        bitcnt_next = BIT_ZERO;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      presc   <= PRESC_ZERO;
      bitcnt  <= BIT_ZERO;
      shreg   <= {DATA_WIDTH{1'b0}};
      o_data  <= {DATA_WIDTH{1'b0}};
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
`ifdef SHIFT_RX_FRAME_CHECK_EN
      o_frame_err <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      presc   <= presc_next;
      bitcnt  <= bitcnt_next;
      shreg   <= shreg_next;
      o_data  <= data_next;
      o_valid <= valid_next;
      // Registered from the next state so it tracks the state register exactly.
      o_busy  <= (state_next != IDLE);
`ifdef SHIFT_RX_FRAME_CHECK_EN
      o_frame_err <= ferr_next;
`endif
    end
  end

endmodule : shift_rx

// File: tb/tb_shift_rx.sv
// -----------------------------------------------------------------------------
// tb_shift_rx
// Directed bench for shift_rx (CLOCKS_PER_BIT=4, DATA_WIDTH=4). Frames that
// should be accepted push their word to a scoreboard queue when driven; a
// negedge monitor pops and compares on every o_valid.
// Latency is counted from the first clock edge that samples the low pin.
// -----------------------------------------------------------------------------
module tb_shift_rx;
  import shift_rx_pkg::*;

  localparam int CPB = 4;
  localparam int DW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ser;
  logic [DW-1:0] data;
  logic          valid;
  logic          busy;
`ifdef SHIFT_RX_FRAME_CHECK_EN
  logic          frame_err;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [DW-1:0] sb[$];
  int   valid_count = 0;
  int   valid_cycle = -1;
  int   busy_rise   = -1;
  int   busy_fall   = -1;
  int   last_fall   = 0;
  int   ferr_count  = 0;
  int   vc_saved    = 0;
  logic prev_valid  = 1'b0;
  logic prev_busy   = 1'b0;
  logic [DW-1:0] popped;

  shift_rx #(
    .CLOCKS_PER_BIT (CPB),
    .DATA_WIDTH     (DW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_serial    (ser),
    .o_data      (data),
    .o_valid     (valid),
    .o_busy      (busy)
`ifdef SHIFT_RX_FRAME_CHECK_EN
    ,
    .o_frame_err (frame_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one full frame starting at a negedge; ends on a negedge.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic accept);
    if (accept) sb.push_back(d);
    last_fall = cycle + 1;
    ser = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      ser = d[i];
      repeat (CPB) @(negedge clk);
    end
    ser = stop;
    repeat (CPB) @(negedge clk);
  endtask

  // Output monitor: scoreboard pops, pulse-width and busy-edge tracking.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        valid_count++;
        valid_cycle = cycle;
        chk("valid_single", 32'(prev_valid), 32'd0);
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL valid_unexpected observed data %0h expected no valid", data);
        end
        if (sb.size() > 0) begin
          popped = sb.pop_front();
          chk("rx_data", 32'(data), 32'(popped));
        end
      end
      if (busy && !prev_busy) busy_rise = cycle;
      if (!busy && prev_busy) busy_fall = cycle;
`ifdef SHIFT_RX_FRAME_CHECK_EN
      if (frame_err) begin
        ferr_count++;
        chk("ferr_no_valid", 32'(valid), 32'd0);
      end
`endif
    end
    prev_valid = valid;
    prev_busy  = busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ser = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data",  32'(data),      32'd0);
    chk("reset_valid", 32'(valid),     32'd0);
    chk("reset_busy",  32'(busy),      32'd0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    chk("reset_sync",  32'(dut.rx_s),  32'd1);
    rst = 1'b0;

    // Idle line: nothing happens.
    repeat (50) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    chk("idle_valid_count", 32'(valid_count), 32'd0);
    chk("idle_data",        32'(data),        32'd0);

    // Single frame 0x5 with latency and busy window.
    send_frame(4'h5, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    chk("f5_valid_count", 32'(valid_count),             32'd1);
    chk("f5_latency",     32'(valid_cycle - last_fall), 32'd24);
    chk("f5_busy_rise",   32'(busy_rise - last_fall),   32'd2);
    chk("f5_busy_fall",   32'(busy_fall - last_fall),   32'd24);
    chk("f5_data",        32'(data),                    32'h5);

    // One-cycle low glitch is rejected.
    ser = 1'b0;
    @(negedge clk);
    ser = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_valid_count", 32'(valid_count), 32'd1);
    chk("glitch_data",        32'(data),        32'h5);
    chk("glitch_busy",        32'(busy),        32'd0);

    // Back-to-back frames with no idle gap.
    send_frame(4'hA, 1'b1, 1'b1);
    send_frame(4'h3, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    chk("b2b_valid_count", 32'(valid_count), 32'd3);
    chk("b2b_data",        32'(data),        32'h3);

`ifdef SHIFT_RX_FRAME_CHECK_EN
    // Bad stop bit, line held low, then recovery and a good frame.
    send_frame(4'h6, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("ferr_busy_low_line", 32'(busy),       32'd1);
    ser = 1'b1;
    repeat (6) @(negedge clk);
    chk("ferr_busy_recover",  32'(busy),        32'd0);
    chk("ferr_count",         32'(ferr_count),  32'd1);
    chk("ferr_valid_count",   32'(valid_count), 32'd3);
    chk("ferr_data_held",     32'(data),        32'h3);
    send_frame(4'h9, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    chk("f9_valid_count", 32'(valid_count), 32'd4);
    chk("f9_data",        32'(data),        32'h9);
`endif

    // Reset during data bit 2 of frame 0xF.
    vc_saved = valid_count;
    ser = 1'b0;
    repeat (CPB) @(negedge clk);
    ser = 1'b1;
    repeat (2 * CPB + 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_mid_valid_count", 32'(valid_count), 32'(vc_saved));
    chk("rst_mid_data",        32'(data),        32'd0);
    chk("rst_mid_busy",        32'(busy),        32'd0);
    chk("rst_mid_state",       32'(dut.state),   32'(IDLE));

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_rx
